// File: rtl/uart_frame_tx.sv
// Purpose: sends a 24-bit value as a framed 8N1 UART packet: HEADER, data[23:16], data[15:8], data[7:0] (+ checksum if CHECKSUM_EN).
// Latency: tx falls the cycle after start is accepted; done pulses the cycle after the final stop bit.
// Backpressure: start is accepted only while busy=0 (including the done cycle); start while busy is ignored.
module uart_frame_tx #(
  parameter int         CLK_FREQ = 50000000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] HEADER   = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] data,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef CHECKSUM_EN
  localparam int NBYTES   = 5;
`else
  localparam int NBYTES   = 4;
`endif
  localparam logic [2:0]    LAST_BYTE = 3'(NBYTES - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [23:0]   shadow;
  logic [7:0]    cur_byte;
  logic          bit_end;
  logic          accept;
  logic          tx_d;
  logic          done_d;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign accept  = (state_q == S_IDLE) && start;
  assign busy    = (state_q != S_IDLE);

`ifdef CHECKSUM_EN
  // Checksum covers the three data bytes only; the header is excluded.
  logic [7:0] csum;
  assign csum = shadow[23:16] + shadow[15:8] + shadow[7:0];
`endif

  // Select the byte currently being serialised.
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      3'd1:    cur_byte = shadow[23:16];
      3'd2:    cur_byte = shadow[15:8];
      3'd3:    cur_byte = shadow[7:0];
`ifdef CHECKSUM_EN
      3'd4:    cur_byte = csum;
`endif
      default: cur_byte = HEADER;
    endcase
  end

  // Next-state and next tx level; tx_d is the line level for the coming cycle.
  always_comb begin
    state_d = state_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_idx];
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = cur_byte[bit_idx + 3'd1];
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (byte_idx == LAST_BYTE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            // Next byte's start bit follows directly, no idle gap.
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered tx/done plus baud, bit and byte counters and the data shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx       <= 1'b1;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shadow   <= '0;
    end else begin
      tx   <= tx_d;
      done <= done_d;

      if (state_q == S_IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state_q != S_DATA) begin
        bit_idx <= '0;
      end else if (bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (state_q == S_IDLE) begin
        byte_idx <= '0;
      end else if (state_q == S_STOP && bit_end && byte_idx != LAST_BYTE) begin
        byte_idx <= byte_idx + 3'd1;
      end

      if (accept) begin
        shadow <= data;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int BD       = 10;
`ifdef CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FL   = NB * 10 * BD;
  localparam int HMAX = 8192;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [23:0] data  = 24'h0;
  logic        busy;
  logic        done;
  logic        tx;

  uart_frame_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .HEADER  (8'hAA)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .busy (busy),
    .done (done),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  // Per-cycle history, sampled on the falling edge.
  logic txh [HMAX];
  logic dh  [HMAX];
  logic bh  [HMAX];
  int   cyc = 0;

  always @(negedge clk) begin
    if (cyc < HMAX) begin
      txh[cyc] = tx;
      dh[cyc]  = done;
      bh[cyc]  = busy;
    end
    cyc = cyc + 1;
  end

  int pass_cnt = 0;
  int total    = 0;

  function automatic logic [7:0] get_byte(input int s, input int k);
    logic [7:0] v;
    int i;
    v = 8'hxx;
    for (int b = 0; b < 8; b++) begin
      i = s + k * 10 * BD + BD * (b + 1) + BD / 2;
      v[b] = (s >= 0 && i < HMAX) ? txh[i] : 1'bx;
    end
    return v;
  endfunction

  // Every bit cell is constant for BD cycles, start bits low, stop bits high.
  function automatic bit cells_ok(input int s, input int nb);
    int   base;
    logic lvl;
    if (s < 0) return 1'b0;
    for (int c = 0; c < nb * 10; c++) begin
      base = s + c * BD;
      if (base + BD > HMAX) return 1'b0;
      lvl = txh[base];
      for (int j = 0; j < BD; j++) begin
        if (txh[base + j] !== lvl) return 1'b0;
      end
      if ((c % 10) == 0 && lvl !== 1'b0) return 1'b0;
      if ((c % 10) == 9 && lvl !== 1'b1) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int first_low(input int from);
    for (int i = from; i < cyc && i < HMAX; i++) begin
      if (txh[i] === 1'b0) return i;
    end
    return -1;
  endfunction

  function automatic int count_done(input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i < to && i < HMAX; i++) begin
      if (dh[i] === 1'b1) n++;
    end
    return n;
  endfunction

  function automatic bit all_high(input int from, input int to);
    if (from < 0) return 1'b0;
    for (int i = from; i < to && i < HMAX; i++) begin
      if (txh[i] !== 1'b1) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit busy_window_ok(input int s, input int len);
    if (s < 0 || s + len >= HMAX) return 1'b0;
    for (int i = s; i < s + len; i++) begin
      if (bh[i] !== 1'b1) return 1'b0;
    end
    return (bh[s + len] === 1'b0);
  endfunction

  // Pulse start for one cycle; nd is the history index of the cycle start is presented in.
  task automatic launch(input logic [23:0] v, output int nd);
    @(posedge clk);
    #2;
    start = 1'b1;
    data  = v;
    nd    = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, input int budget, output int idx);
    idx = -1;
    for (int i = 0; i < budget && idx < 0; i++) begin
      @(negedge clk);
      #1;
      if (cyc - 1 >= from && cyc - 1 < HMAX && dh[cyc - 1] === 1'b1) idx = cyc - 1;
    end
  endtask

  task automatic test_reset;
    int base;
    bit ok;
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    #1 rst = 1'b1;
    base = cyc;
    repeat (100) @(negedge clk);
    #1;
    ok = 1'b1;
    for (int i = base; i < cyc; i++) begin
      if (txh[i] !== 1'b1 || bh[i] !== 1'b0 || dh[i] !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) $display("FAIL idle_quiet: got activity expected tx=1 busy=0 done=0"); else pass_cnt++;
  endtask

  task automatic test_single_frame;
    int nd, s, di, nd_cnt;
    logic [7:0] e [5];
    logic [7:0] g;
    e = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C};
    launch(24'h123456, nd);
    // Start request mid-frame with different data must be ignored.
    repeat (150) @(posedge clk);
    #2;
    start = 1'b1;
    data  = 24'hFFFFFF;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(nd, FL + 300, di);
    repeat (20) @(negedge clk);
    #1;
    s = first_low(nd);
    total++;
    if (s !== nd + 1) $display("FAIL single_latency: got %0d expected %0d", s, nd + 1); else pass_cnt++;
    for (int k = 0; k < NB; k++) begin
      g = get_byte(s, k);
      total++;
      if (g !== e[k]) $display("FAIL single_byte%0d: got %h expected %h", k, g, e[k]); else pass_cnt++;
    end
    total++;
    if (!cells_ok(s, NB)) $display("FAIL single_bit_timing: got bad cells expected %0d-cycle bits", BD); else pass_cnt++;
    total++;
    if (di !== s + FL) $display("FAIL single_done_time: got %0d expected %0d", di, s + FL); else pass_cnt++;
    nd_cnt = count_done(nd, cyc);
    total++;
    if (nd_cnt !== 1) $display("FAIL single_done_count: got %0d expected 1", nd_cnt); else pass_cnt++;
    total++;
    if (!busy_window_ok(s, FL)) $display("FAIL single_busy: got gap expected busy for %0d cycles", FL); else pass_cnt++;
    total++;
    if (!all_high(s + FL, cyc)) $display("FAIL single_no_restart: got tx low expected idle after frame"); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int nd, dcyc, s2, di2;
    bit got;
    logic [7:0] e [5];
    logic [7:0] g;
    e = '{8'hAA, 8'h00, 8'h00, 8'h01, 8'h01};
    launch(24'hABCDEF, nd);
    got  = 1'b0;
    dcyc = -1;
    for (int i = 0; i < FL + 300 && !got; i++) begin
      @(posedge clk);
      #2;
      if (done === 1'b1) begin
        start = 1'b1;
        data  = 24'h000001;
        got   = 1'b1;
        dcyc  = cyc;
      end
    end
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(dcyc + 1, FL + 300, di2);
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (!got) $display("FAIL b2b_first_done: got none expected done pulse"); else pass_cnt++;
    total++;
    if (dcyc < 0 || bh[dcyc] !== 1'b0) $display("FAIL b2b_busy_in_done: got busy=1 expected 0"); else pass_cnt++;
    s2 = first_low(dcyc);
    total++;
    if (s2 !== dcyc + 1) $display("FAIL b2b_gap: got %0d expected %0d", s2, dcyc + 1); else pass_cnt++;
    for (int k = 0; k < NB; k++) begin
      g = get_byte(s2, k);
      total++;
      if (g !== e[k]) $display("FAIL b2b_byte%0d: got %h expected %h", k, g, e[k]); else pass_cnt++;
    end
    total++;
    if (!cells_ok(s2, NB)) $display("FAIL b2b_bit_timing: got bad cells expected %0d-cycle bits", BD); else pass_cnt++;
    total++;
    if (di2 !== s2 + FL) $display("FAIL b2b_done_time: got %0d expected %0d", di2, s2 + FL); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    int nd, s, di, base;
    logic [7:0] e [5];
    logic [7:0] g;
    e = '{8'hAA, 8'h65, 8'h43, 8'h21, 8'hC9};
    launch(24'h123456, nd);
    // Byte 2 (0x34), bit 1: line is low here.
    for (int i = 0; i < FL && cyc < nd + 1 + 225; i++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (tx !== 1'b0) $display("FAIL midreset_precond: got tx=%b expected 0", tx); else pass_cnt++;
    rst = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1) $display("FAIL midreset_tx: got %b expected 1", tx); else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    base = cyc;
    repeat (30) @(negedge clk);
    #1;
    total++;
    if (!all_high(base, cyc) || count_done(base, cyc) != 0) $display("FAIL midreset_quiet: got activity expected idle"); else pass_cnt++;
    launch(24'h654321, nd);
    wait_done(nd, FL + 300, di);
    repeat (5) @(negedge clk);
    #1;
    s = first_low(nd);
    for (int k = 0; k < NB; k++) begin
      g = get_byte(s, k);
      total++;
      if (g !== e[k]) $display("FAIL midreset_byte%0d: got %h expected %h", k, g, e[k]); else pass_cnt++;
    end
    total++;
    if (di !== s + FL || s !== nd + 1) $display("FAIL midreset_done_time: got %0d expected %0d", di, nd + 1 + FL); else pass_cnt++;
  endtask

  task automatic test_all_ones;
    int nd, s, di;
    logic [7:0] e [5];
    logic [7:0] g;
    e = '{8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
    launch(24'hFFFFFF, nd);
    wait_done(nd, FL + 300, di);
    repeat (30) @(negedge clk);
    #1;
    s = first_low(nd);
    for (int k = 0; k < NB; k++) begin
      g = get_byte(s, k);
      total++;
      if (g !== e[k]) $display("FAIL ones_byte%0d: got %h expected %h", k, g, e[k]); else pass_cnt++;
    end
    total++;
    if (di !== s + FL) $display("FAIL ones_done_time: got %0d expected %0d", di, s + FL); else pass_cnt++;
    total++;
    if (!all_high(s + FL, cyc)) $display("FAIL ones_frame_length: got extra bits expected idle after %0d cycles", FL); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_reset_midframe;
    test_all_ones;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
